// File: rtl/crt_recombine.sv
// rtl/crt_recombine.sv - bit-serial CRT recombination m = m2 + q*(((m1-m2) mod p)*qinv mod p)
// Optional input range checking is built when CRT_RANGE_CHECK_EN is defined.
module crt_recombine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] p,
    input  logic [31:0] q,
    input  logic [31:0] m1,
    input  logic [31:0] m2,
    input  logic [31:0] qinv,
    output logic [63:0] m,
    output logic        done,
    output logic        busy,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, REDUCE, DIFF, MULMOD, MULQ, FINAL} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] p_r, q_r, m1_r, m2_r, qinv_r;
    logic [31:0] sh;
    logic [32:0] acc;
    logic [63:0] prod;

    logic [32:0] p_x;
    logic [32:0] red_sh, red_nx;
    logic [32:0] mm_dbl, mm_red, mm_add, mm_nx;
    logic [32:0] diff_nx;
    logic [63:0] mulq_nx;

    // sh is a shared operand shift register: m2 in REDUCE, d in MULMOD, h in MULQ
    always_comb begin
        p_x     = {1'b0, p_r};
        red_sh  = {acc[31:0], sh[31]};
        red_nx  = (red_sh >= p_x) ? red_sh - p_x : red_sh;
        mm_dbl  = {acc[31:0], 1'b0};
        mm_red  = (mm_dbl >= p_x) ? mm_dbl - p_x : mm_dbl;
        mm_add  = sh[31] ? mm_red + {1'b0, qinv_r} : mm_red;
        mm_nx   = (mm_add >= p_x) ? mm_add - p_x : mm_add;
        diff_nx = ({1'b0, m1_r} >= acc) ? {1'b0, m1_r} - acc : {1'b0, m1_r} + p_x - acc;
        mulq_nx = sh[0] ? prod + ({32'b0, q_r} << cnt) : prod;
    end

`ifdef CRT_RANGE_CHECK_EN
    logic err_q;
    logic bad;
    logic viol;
    assign viol = (p == 32'd0) || (m1 >= p) || (m2 >= q) || (qinv >= p);
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            p_r    <= 32'd0;
            q_r    <= 32'd0;
            m1_r   <= 32'd0;
            m2_r   <= 32'd0;
            qinv_r <= 32'd0;
            sh     <= 32'd0;
            acc    <= 33'd0;
            prod   <= 64'd0;
            m      <= 64'd0;
            done   <= 1'b0;
            busy   <= 1'b0;
`ifdef CRT_RANGE_CHECK_EN
            err_q  <= 1'b0;
            bad    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        p_r    <= p;
                        q_r    <= q;
                        m1_r   <= m1;
                        m2_r   <= m2;
                        qinv_r <= qinv;
                        sh     <= m2;
                        acc    <= 33'd0;
                        cnt    <= 5'd0;
                        busy   <= 1'b1;
                        state  <= REDUCE;
`ifdef CRT_RANGE_CHECK_EN
                        if (viol) begin
                            bad   <= 1'b1;
                            state <= FINAL;
                        end else begin
                            bad   <= 1'b0;
                            err_q <= 1'b0;
                        end
`endif
                    end else begin
                        busy <= 1'b0;
                    end
                end
                REDUCE: begin
                    acc <= red_nx;
                    sh  <= {sh[30:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= DIFF;
                end
                DIFF: begin
                    sh    <= diff_nx[31:0];
                    acc   <= 33'd0;
                    state <= MULMOD;
                end
                MULMOD: begin
                    acc <= mm_nx;
                    sh  <= {sh[30:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        sh    <= mm_nx[31:0];
                        prod  <= 64'd0;
                        state <= MULQ;
                    end
                end
                MULQ: begin
                    prod <= mulq_nx;
                    sh   <= {1'b0, sh[31:1]};
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FINAL;
                end
                FINAL: begin
                    m     <= prod + {32'd0, m2_r};
                    done  <= 1'b1;
                    state <= IDLE;
`ifdef CRT_RANGE_CHECK_EN
                    if (bad) begin
                        m     <= 64'd0;
                        err_q <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/crt_recombine.md
# crt_recombine

Chinese-Remainder recombination stage of the RSA decryption datapath. It consumes the half-exponentiation results m1 = c^dp mod p and m2 = c^dq mod q, together with p, q and qinv = q^-1 mod p from the modular-inverse block. It produces the 64-bit plaintext m = m2 + q·(((m1 − m2) mod p)·qinv mod p). All arithmetic is bit-serial, using one adder/subtractor chain per step, so area stays small at the cost of about 100 cycles of latency.

## Interface
- No parameters; the operand width is fixed at 32 bits and the result width at 64 bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- p, q  in  32  prime moduli; p odd, nonzero.
- m1  in  32  c^dp mod p; must satisfy m1 < p.
- m2  in  32  c^dq mod q; must satisfy m2 < q (may be ≥ p).
- qinv  in  32  q^-1 mod p; must satisfy qinv < p.
- m  out  64  recombined plaintext; held until the next accepted start.
- done  out  1  one-cycle pulse when m is valid.
- busy  out  1  high from the cycle after start is accepted until done.
- err  out  1  input-range violation flag (see Configuration).

## Operation
- States: IDLE, REDUCE, DIFF, MULMOD, MULQ, FINAL.
- IDLE: on start=1, register p, q, m1, m2 and qinv internally, then go to REDUCE. Inputs may change after the capture edge.
- REDUCE (32 cycles): restoring reduction, MSB first, computes r = m2 mod p. The working remainder is 33 bits.
- DIFF (1 cycle): d = (m1 ≥ r) ? m1 − r : m1 + p − r, computed with a 33-bit intermediate, so d < p.
- MULMOD (32 cycles): interleaved modular multiply, scanning d MSB first. Each step does acc = 2·acc mod p, then adds qinv if the current bit is set, then reduces mod p. Intermediates are 33 bits. The result is h = acc < p.
- MULQ (32 cycles): shift-add, scanning h LSB first, computes prod = h·q in a 64-bit accumulator.
- FINAL (1 cycle): m ← prod + m2 (64-bit add, cannot overflow), done ← 1, then go to IDLE.
- start while busy is ignored; requests are not queued.
- rst_n low at any time, including mid-operation: state goes to IDLE immediately, and m, done, busy and err all go to 0.

## Timing
- Edge 0: start is sampled high in IDLE; busy = 1 after this edge.
- Edges 1–32: REDUCE. Edge 33: DIFF. Edges 34–65: MULMOD. Edges 66–97: MULQ. Edge 98: FINAL.
- After edge 98: done = 1 and m is valid. After edge 99: done = 0, busy = 0, and the block is in IDLE.
- Latency from the start edge to done is exactly 98 cycles.
- A new start may be sampled at edge 99 at the earliest.
- m updates only at FINAL (or to 0 on reset); it is stable at all other times.
- Reset values: m = 0, done = 0, busy = 0, err = 0, state = IDLE.

## Configuration
- Macro: CRT_RANGE_CHECK_EN.
- Defined: at the start edge, the block tests p == 0, m1 ≥ p, m2 ≥ q and qinv ≥ p.
  - On any violation: go directly to FINAL. At the next edge, set m = 0, err = 1 and done = 1 (latency 1). Return to IDLE.
  - err is held until the next accepted start or reset.
  - On a legal start, err is cleared at the start edge.
- Not defined: no check logic is built and err is tied to 0. Results for out-of-range inputs are unspecified, but the block must still assert done at 98 cycles and return to IDLE.

## Test plan
- p=61, q=53, qinv=38, m1=4, m2=12 -> done after 98 cycles, m=65, err=0.
- p=53, q=61, qinv=20, m1=52, m2=60 (m2 ≥ p exercises REDUCE) -> m=3232.
- p=61, q=53, qinv=38, m1=0, m2=0 -> m=0. Then back-to-back start at edge 99 with m1=60, m2=52 -> m=3232.
- start pulsed at edges 10 and 50 of an active operation -> both ignored; a single done at edge 98; m=65.
- rst_n low at edge 40 of an operation, then released -> m=0, done=0, busy=0. A fresh start then gives the correct m=65.
- With CRT_RANGE_CHECK_EN defined: p=61, m1=61 -> done one cycle after start, m=0, err=1. Without the macro: err stays 0.
